// File: rtl/nn_pkg.sv
// Shared types and constants for the layer scheduler and neuron engine interface.
package nn_pkg;

  localparam int NEURON_DATA_W = 8;
  localparam int CTRL_W        = 2;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'b000,
    ST_LAUNCH    = 3'b001,
    ST_WAIT_ACK  = 3'b010,
    ST_WAIT_DONE = 3'b011,
    ST_CAPTURE   = 3'b100,
    ST_DONE      = 3'b101
  } state_t;

endpackage

// File: rtl/layer_scheduler_if.sv
// Scheduler <-> shared neuron engine handshake bundle.
interface layer_scheduler_if #(
  parameter int IDX_W = 8
);
  import nn_pkg::*;

  logic [IDX_W-1:0]         neuron_sel;
  logic [CTRL_W-1:0]        neuron_ctrl_data;
  logic                     neuron_start;
  logic                     neuron_ready;
  logic [NEURON_DATA_W-1:0] neuron_out;

  modport master (
    output neuron_sel, neuron_ctrl_data, neuron_start,
    input  neuron_ready, neuron_out
  );

  modport slave (
    input  neuron_sel, neuron_ctrl_data, neuron_start,
    output neuron_ready, neuron_out
  );
endinterface

// File: rtl/handshake_timer.sv
// Wait-cycle counter for one engine handshake edge; expired marks the last allowed cycle.
module handshake_timer #(
  parameter int TIMEOUT = 1023
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      cnt <= '0;
    else if (clear)  cnt <= '0;
    else if (enable) cnt <= cnt + CW'(1);
  end

  // cnt holds the number of wait cycles already spent, so TIMEOUT-1 is the final one
  assign expired = (cnt == CW'(TIMEOUT - 1));
endmodule

// File: rtl/layer_scheduler.sv
// Runs every neuron of a layer through one shared engine and packs the 8-bit results.
module layer_scheduler
  import nn_pkg::*;
#(
  parameter int NEURON_COUNT = 10,
  parameter int IDX_W        = 8,
  parameter int TIMEOUT      = 1023
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  layer_start,
  input  logic [CTRL_W-1:0]                     ctrl_data,
  output logic                                  layer_busy,
  output logic                                  layer_done,
  output logic                                  timeout_err,
  output logic [NEURON_COUNT*NEURON_DATA_W-1:0] layer_outputs,
  layer_scheduler_if.master                     eng
);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NEURON_COUNT - 1);

  state_t                                        state, state_nxt;
  logic [IDX_W-1:0]                              idx;
  logic [CTRL_W-1:0]                             ctrl_q;
  logic [NEURON_COUNT-1:0][NEURON_DATA_W-1:0]    out_buf;
  logic                                          tmr_clr, tmr_en, tmr_exp, tmo_hit;

  handshake_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (tmr_clr),
    .enable  (tmr_en),
    .expired (tmr_exp)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    tmr_clr   = 1'b0;
    tmr_en    = 1'b0;
    tmo_hit   = 1'b0;
    case (state)
      ST_IDLE:   if (layer_start) state_nxt = ST_LAUNCH;
      ST_LAUNCH: begin
        tmr_clr   = 1'b1;
        state_nxt = ST_WAIT_ACK;
      end
      // ready still high here is the previous result, never a completion
      ST_WAIT_ACK: begin
        tmr_en = 1'b1;
        if (!eng.neuron_ready) begin
          tmr_clr   = 1'b1;
          state_nxt = ST_WAIT_DONE;
        end else if (tmr_exp) begin
          tmo_hit   = 1'b1;
          state_nxt = ST_DONE;
        end
      end
      ST_WAIT_DONE: begin
        tmr_en = 1'b1;
        if (eng.neuron_ready) state_nxt = ST_CAPTURE;
        else if (tmr_exp) begin
          tmo_hit   = 1'b1;
          state_nxt = ST_DONE;
        end
      end
      ST_CAPTURE: state_nxt = (idx == LAST_IDX) ? ST_DONE : ST_LAUNCH;
      ST_DONE:    state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx         <= '0;
      ctrl_q      <= '0;
      out_buf     <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (state == ST_IDLE && layer_start) begin
        idx         <= '0;
        ctrl_q      <= ctrl_data;
        timeout_err <= 1'b0;
      end
      if (state == ST_CAPTURE) begin
        for (int k = 0; k < NEURON_COUNT; k++)
          if (idx == IDX_W'(k)) out_buf[k] <= eng.neuron_out;
        if (idx != LAST_IDX) idx <= idx + IDX_W'(1);
      end
      if (tmo_hit) timeout_err <= 1'b1;
    end
  end

  assign layer_busy           = (state != ST_IDLE);
  assign layer_done           = (state == ST_DONE);
  assign layer_outputs        = out_buf;
  assign eng.neuron_start     = (state == ST_LAUNCH);
  assign eng.neuron_sel       = idx;
  assign eng.neuron_ctrl_data = ctrl_q;
endmodule
